// File: rtl/div.sv
`default_nettype none
// ============================================================================
// div : multi-cycle restoring divider (signed/unsigned), one quotient bit/cycle
// Optional macro DIV_ZERO_FLAG_EN adds div_zero_o.   Rev 1.0
// ============================================================================
module div #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
`ifdef DIV_ZERO_FLAG_EN
   output logic               div_zero_o,
`endif
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);
   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               ready_q, ready_d;
`ifdef DIV_ZERO_FLAG_EN
   logic               dz_q, dz_d;
`endif

   logic               op1_neg, op2_neg;
   logic [WIDTH-1:0]   abs1, abs2;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   rem_step, quo_step;

   // dvd_q shifts the dividend out of its MSB while quotient bits enter at the LSB
   always_comb begin
      op1_neg = signed_div_i & opdata1_i[WIDTH-1];
      op2_neg = signed_div_i & opdata2_i[WIDTH-1];
      abs1    = op1_neg ? -opdata1_i : opdata1_i;
      abs2    = op2_neg ? -opdata2_i : opdata2_i;
      trial   = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
      if (!trial[WIDTH]) begin
         rem_step = trial[WIDTH-1:0];
         quo_step = {dvd_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_step = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
         quo_step = {dvd_q[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      ready_d   = ready_q;
`ifdef DIV_ZERO_FLAG_EN
      dz_d      = dz_q;
`endif
      case (state_q)
         S_FREE: begin
            ready_d  = 1'b0;
            result_d = '0;
`ifdef DIV_ZERO_FLAG_EN
            dz_d     = 1'b0;
`endif
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_d = S_BYZERO;
               end else begin
                  state_d   = S_ON;
                  dvd_d     = abs1;
                  dvs_d     = abs2;
                  neg_rem_d = op1_neg;
                  neg_quo_d = op1_neg ^ op2_neg;
                  cnt_d     = '0;
                  rem_d     = '0;
               end
            end
         end
         S_BYZERO: begin
            if (annul_i) begin
               state_d = S_FREE;
            end else begin
               state_d  = S_END;
               result_d = '0;
               ready_d  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
               dz_d     = 1'b1;
`endif
            end
         end
         S_ON: begin
            if (annul_i) begin
               state_d  = S_FREE;
               ready_d  = 1'b0;
               result_d = '0;
            end else begin
               rem_d = rem_step;
               dvd_d = quo_step;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_d  = S_END;
                  ready_d  = 1'b1;
                  result_d = {neg_rem_q ? -rem_step : rem_step,
                              neg_quo_q ? -quo_step : quo_step};
               end
            end
         end
         S_END: begin
            if (!start_i) begin
               state_d  = S_FREE;
               ready_d  = 1'b0;
               result_d = '0;
`ifdef DIV_ZERO_FLAG_EN
               dz_d     = 1'b0;
`endif
            end
         end
         default: state_d = S_FREE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FREE;
         cnt_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         ready_q   <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
         dz_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
         dz_q      <= dz_d;
`endif
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
   assign div_zero_o = dz_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div.sv
`default_nettype none
// tb_div : randomized scoreboard bench for div (WIDTH=32) with arithmetic reference model
module tb_div;
   localparam int WIDTH = 32;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               signed_div_i = 1'b0;
   logic [WIDTH-1:0]   opdata1_i = '0;
   logic [WIDTH-1:0]   opdata2_i = '0;
   logic               start_i = 1'b0;
   logic               annul_i = 1'b0;
   logic [2*WIDTH-1:0] result_o;
   logic               ready_o;
`ifdef DIV_ZERO_FLAG_EN
   logic               div_zero_o;
`endif

   div #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
`ifdef DIV_ZERO_FLAG_EN
      .div_zero_o   (div_zero_o),
`endif
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      logic        dz;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   logic ready_prev = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Reference: plain integer division in 64-bit arithmetic (truncation toward zero)
   function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      sa = sgn ? longint'($signed(a)) : longint'(a);
      sb = sgn ? longint'($signed(b)) : longint'(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (ready_o && !ready_prev) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: got ready=1 with result %h, required no result", result_o);
         end else begin
            e = exp_q.pop_front();
            chk("result", result_o, e.res);
`ifdef DIV_ZERO_FLAG_EN
            chk("div_zero", {63'd0, div_zero_o}, {63'd0, e.dz});
`endif
         end
      end
      ready_prev = ready_o;
   end

   task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output logic [63:0] got);
      exp_t e;
      int   n, hold;
      e.res = model(sgn, a, b);
      e.dz  = (b == 32'd0);
      @(negedge clk);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      annul_i      = 1'b0;
      exp_q.push_back(e);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
         if (scramble) begin
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom);
         end
      end while (!ready_o && n < 200);
      chk("latency", 64'(n), (b == 32'd0) ? 64'd2 : 64'(WIDTH + 1));
      got  = result_o;
      hold = $urandom_range(0, 2);
      for (int i = 0; i < hold; i++) begin
         annul_i = 1'($urandom);
         @(posedge clk);
         #1;
         chk("end_hold", {63'd0, ready_o}, 64'd1);
      end
      start_i = 1'b0;
      annul_i = 1'b0;
      @(posedge clk);
      #1;
      chk("drop_ready", {63'd0, ready_o}, 64'd0);
      chk("drop_result", result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
      chk("drop_div_zero", {63'd0, div_zero_o}, 64'd0);
`endif
   endtask

   initial begin
      logic [63:0] got;
      logic [31:0] a, b;
      logic        s;

      #3;
      chk("reset_ready", {63'd0, ready_o}, 64'd0);
      chk("reset_result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op(1'b0, 32'd100, 32'd7, 1'b0, got);
      chk("u100_7", got, {32'd2, 32'd14});
      run_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, got);
      chk("s_m7_2", got, {32'hFFFFFFFF, 32'hFFFFFFFD});
      run_op(1'b1, 32'd7, 32'hFFFFFFFE, 1'b0, got);
      chk("s_7_m2", got, {32'd1, 32'hFFFFFFFD});
      run_op(1'b0, 32'h1234, 32'd0, 1'b0, got);
      chk("by_zero", got, 64'd0);

      // Annul at iteration 10
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      repeat (11) @(posedge clk);
      #1 annul_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      annul_i = 1'b0;
      chk("annul_ready", {63'd0, ready_o}, 64'd0);
      chk("annul_result", result_o, 64'd0);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 chk("annul_quiet", {63'd0, ready_o}, 64'd0);
      end
      run_op(1'b0, 32'd9, 32'd3, 1'b0, got);
      chk("u9_3", got, {32'd0, 32'd3});

      // Reset mid-operation at iteration 20
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      repeat (21) @(posedge clk);
      #2 rst = 1'b0;
      start_i = 1'b0;
      #1;
      chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
      chk("rst_mid_result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      run_op(1'b0, 32'hFFFFFFFF, 32'h10, 1'b0, got);
      chk("u_ff_10", got, {32'hF, 32'h0FFFFFFF});

      // Asynchronous reset while a result is being presented
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd6; start_i = 1'b1;
      exp_q.push_back('{res: model(1'b0, 32'd50, 32'd6), dz: 1'b0});
      repeat (WIDTH + 2) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_end_ready", {63'd0, ready_o}, 64'd0);
      chk("rst_end_result", result_o, 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, got);
      chk("s_min_m1", got, {32'd0, 32'h80000000});
      run_op(1'b0, 32'hDEADBEEF, 32'h1357, 1'b1, got);

      for (int k = 0; k < 24; k++) begin
         s = 1'($urandom);
         a = (k % 7 == 3) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 4))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 20);
            2:       b = 32'hFFFFFFFF;
            default: b = $urandom;
         endcase
         run_op(s, a, b, 1'($urandom), got);
      end

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/div.md
Name: div

Overview:
- Multi-cycle restoring divider. It is the responder for the divide handshake issued by the execute stage.
- EX raises start with operands and holds it. `div` iterates one quotient bit per cycle, then returns {remainder, quotient} with ready.
- EX writes the result into HI/LO: HI = remainder, LO = quotient.
- Supports signed (DIV) and unsigned (DIVU) division. Supports cancellation (annul) when the pipeline flushes.

Parameters:
- WIDTH, 32, operand width in bits; must be >= 2. Iteration counter width is clog2(WIDTH+1).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; one clock; reset is asynchronous and active-low (asserted when 0)
- signed_div_i  input  1  1 = signed divide, 0 = unsigned
- opdata1_i  input  WIDTH  dividend
- opdata2_i  input  WIDTH  divisor
- start_i  input  1  request; held high by EX until it has consumed ready_o
- annul_i  input  1  cancel the in-flight divide
- result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
- ready_o  output  1  result valid

Behaviour:
- Reset (async, rst=0): state=FREE, ready_o=0, result_o=0, counter=0, internal registers=0.
- States are FREE, BYZERO, ON and END. All outputs are registered.
- FREE:
  - start_i=1, annul_i=0, opdata2_i==0: go to BYZERO.
  - start_i=1, annul_i=0, opdata2_i!=0: go to ON. Latch absolute operand values (two's-complement negate when signed_div_i=1 and MSB=1), the sign of the dividend, and the sign XOR of both operands. Clear the counter and the partial remainder.
  - start_i=1 together with annul_i=1: stay in FREE.
  - Otherwise: stay in FREE, ready_o=0, result_o=0.
- Operands and signed_div_i are sampled only on the FREE->ON edge. Later changes are ignored.
- ON: each edge performs one restoring step.
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor (WIDTH+1-bit subtract). If non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
  - Counter increments.
  - When the counter reaches WIDTH: go to END.
    - Quotient is negated if the sign XOR is set (signed only).
    - Remainder is negated if the dividend was negative (signed only); remainder takes the dividend's sign.
    - result_o = {rem, quo}, ready_o=1.
- ON with annul_i=1 at an edge: go to FREE, ready_o=0, result_o=0. This takes priority over the iteration, including the final one.
- BYZERO: the next edge goes to END with result_o=0 and ready_o=1. If annul_i=1 at that edge, go to FREE instead.
- END:
  - While start_i=1: hold result_o and ready_o=1. annul_i is ignored.
  - On an edge with start_i=0: go to FREE, ready_o=0, result_o=0.
- Latency, measured from the edge sampling start in FREE:
  - Nonzero divisor: ready_o rises after WIDTH+1 edges (33 for WIDTH=32).
  - Zero divisor: ready_o rises after 2 edges.
- Signed corner case: most-negative / -1 gives quotient = most-negative (wraps) and remainder 0. No trap.
- Asynchronous reset mid-operation aborts immediately to the reset values. There is no partial result.
- The ready_o pulse width equals the number of cycles start_i stays high in END. It is at least 1 cycle if EX drops start_i on the cycle after it sees ready.

Optional Feature:
- Macro DIV_ZERO_FLAG_EN.
- Defined: adds output port div_zero_o (1 bit).
  - Registered; set on the BYZERO->END edge together with ready_o.
  - Held while in END; cleared whenever ready_o clears, on annul, and on reset.
  - Lets EX/CP0 raise an optional divide-by-zero indication.
- Undefined: no port. Divide-by-zero returns result_o=0 with ready_o=1 silently; behaviour is otherwise identical.

Test Plan:
- Unsigned: signed_div_i=0, op1=100, op2=7, start held. Required: ready_o=1 exactly 33 edges after the start edge; result_o={32'd2, 32'd14}. Drop start: ready_o=0 and state FREE next edge.
- Signed: op1=0xFFFFFFF9 (-7), op2=2.
  - Required: quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
  - Also op1=7, op2=0xFFFFFFFE: quotient=0xFFFFFFFD, remainder=1.
- Divide by zero: op1=0x1234, op2=0.
  - Required: ready_o=1 after 2 edges; result_o=0.
  - With DIV_ZERO_FLAG_EN: div_zero_o=1 with ready_o, then 0 after start drops.
- Annul: start 100/7, assert annul_i for one cycle at iteration 10. Required: FREE next edge, ready_o never rises, result_o=0. A new start of 9/3 then yields {0, 3} after 33 edges.
- Reset mid-operation: pull rst low at iteration 20. Required: ready_o=0 and result_o=0 immediately, without waiting for a clock. After release, 0xFFFFFFFF/0x10 unsigned gives {0xF, 0x0FFFFFFF}.
- Operand stability and boundary: change opdata1_i/opdata2_i every cycle during ON; the result must match the operands sampled at start. Signed 0x80000000/0xFFFFFFFF gives {0, 0x80000000}.
